mdu_hilo: RTL and testbench



---
 rtl/mdu_hilo.sv | 131 +++++++++++++
 tb/tb_mdu_hilo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Sequential multiply/divide unit with HI/LO registers. Latency is WIDTH+1 cycles per mult/div, or 1 cycle for a divide by zero.
// The CPU stalls while busy is high; start, op, x and y are ignored until the cycle after done.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_MTHI = 4'b1101;
  localparam logic [3:0] OP_MTLO = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc, acc_step;
  logic [WIDTH-1:0] m;
  logic             is_div;
  logic [WIDTH:0]   booth_sum, div_shift, div_trial;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && op == OP_MULT)
          state_nxt = CALC;
        else if (start && op == OP_DIV)
          state_nxt = (y == '0) ? FINISH : CALC;
      end
      CALC:    if (last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth adds in WIDTH+1 bits so a -2^(WIDTH-1) multiplicand cannot corrupt the shifted-in sign.
  always_comb begin
    booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = booth_sum + {m[WIDTH-1], m};
      2'b10:   booth_sum = booth_sum - {m[WIDTH-1], m};
      default: booth_sum = booth_sum;
    endcase
    // Divide packs the partial remainder in acc[2W:W] and the dividend/quotient in acc[W-1:0].
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, m};
    if (is_div)
      acc_step = {(div_trial[WIDTH] ? div_shift : div_trial), acc[WIDTH-2:0], ~div_trial[WIDTH]};
    else
      acc_step = {booth_sum, acc[WIDTH:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      m           <= '0;
      is_div      <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                acc         <= {{WIDTH{1'b0}}, y, 1'b0};
                m           <= x;
                is_div      <= 1'b0;
                cnt         <= '0;
                div_by_zero <= 1'b0;
              end
              OP_DIV: begin
                if (y == '0) begin
                  lo          <= '1;
                  hi          <= x;
                  div_by_zero <= 1'b1;
                end else begin
                  acc         <= {{(WIDTH+1){1'b0}}, x};
                  m           <= y;
                  is_div      <= 1'b1;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                end
              end
              OP_MTHI: hi <= x;
              OP_MTLO: lo <= x;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (last) begin
            if (is_div) begin
              hi <= acc_step[2*WIDTH-1:WIDTH];
              lo <= acc_step[WIDTH-1:0];
            end else begin
              hi <= acc_step[2*WIDTH:WIDTH+1];
              lo <= acc_step[WIDTH:1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed table, handshake/reset sequences and random ops against an arithmetic model.
module tb_mdu_hilo;

  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_MTHI = 4'b1101;
  localparam logic [3:0] OP_MTLO = 4'b1110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] x, y;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to done; returns done latency, busy cycle count and hi/lo hold flag.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit interfere, output int lat, output int bcnt, output bit hold);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; hold = 1'b1; lat = -1; bcnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0; op = 4'h0; x = 32'h0; y = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) bcnt++;
      if (interfere && k == 5) begin
        start = 1'b1; op = OP_MTLO; x = 32'hDEADBEEF; y = 32'h1;
      end else if (interfere && k == 6) begin
        start = 1'b1; op = OP_MULT; x = 32'h11111111; y = 32'h3;
      end else begin
        start = 1'b0; op = 4'h0;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (hi !== h0 || lo !== l0) hold = 1'b0;
    end
    start = 1'b0; op = 4'h0;
  endtask

  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed, output int elat);
    longint p;
    if (o == OP_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      eh = p[63:32]; el = p[31:0]; ed = 1'b0; elat = 33;
    end else if (b == 0) begin
      eh = a; el = 32'hFFFFFFFF; ed = 1'b1; elat = 1;
    end else begin
      eh = a % b; el = a / b; ed = 1'b0; elat = 33;
    end
  endtask

  task automatic apply(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit interfere);
    int lat, bcnt, elat;
    bit hold;
    logic [31:0] eh, el;
    logic ed;
    model(o, a, b, eh, el, ed, elat);
    do_op(o, a, b, interfere, lat, bcnt, hold);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
    chk({tag, " busy cycles"}, 64'(bcnt), 64'(elat));
    if (elat > 1) chk({tag, " hi/lo held during calc"}, 64'(hold), 64'(1));
  endtask

  vec_t tbl[$];

  initial begin
    bit saw_done;
    logic [3:0] ro;
    logic [31:0] rx, ry;

    rst_n = 1'b0; start = 1'b0; op = 4'h0; x = 32'h0; y = 32'h0;
    #23;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset dbz", 64'(div_by_zero), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{OP_MULT, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    tbl.push_back('{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0});
    tbl.push_back('{OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1,        1'b0});
    tbl.push_back('{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
    tbl.push_back('{OP_DIV,  32'hFFFFFFFF, 32'h2,        32'h1,        32'h7FFFFFFF, 1'b0});
    tbl.push_back('{OP_DIV,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{OP_MULT, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    tbl.push_back('{OP_DIV,  32'h5,        32'h9,        32'h5,        32'h0,        1'b0});

    foreach (tbl[i]) begin
      int lat, bcnt, elat;
      bit hold;
      do_op(tbl[i].op, tbl[i].x, tbl[i].y, 1'b0, lat, bcnt, hold);
      elat = tbl[i].dbz ? 1 : 33;
      chk($sformatf("tbl%0d latency", i), 64'(lat), 64'(elat));
      chk($sformatf("tbl%0d hi", i), 64'(hi), 64'(tbl[i].hi));
      chk($sformatf("tbl%0d lo", i), 64'(lo), 64'(tbl[i].lo));
      chk($sformatf("tbl%0d div_by_zero", i), 64'(div_by_zero), 64'(tbl[i].dbz));
      chk($sformatf("tbl%0d busy cycles", i), 64'(bcnt), 64'(elat));
    end

    // MTHI writes hi directly with no busy
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; x = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0; op = 4'h0;
    chk("mthi hi", 64'(hi), 64'(32'hA5A5A5A5));
    chk("mthi busy", 64'(busy), 64'(0));
    chk("mthi done", 64'(done), 64'(0));

    // MTLO/mult pulses during a divide must be ignored
    apply("div interfered", OP_DIV, 32'd1000, 32'd3, 1'b1);

    // Reset mid-mult aborts asynchronously; no done afterwards
    @(negedge clk);
    start = 1'b1; op = OP_MULT; x = 32'h12345; y = 32'h777;
    @(negedge clk);
    start = 1'b0; op = 4'h0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort hi", 64'(hi), 64'(0));
    chk("abort lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("no done after abort", 64'(saw_done), 64'(0));

    for (int i = 0; i < 24; i++) begin
      ro = ($urandom_range(0, 1) != 0) ? OP_MULT : OP_DIV;
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'h0;
        1:       ry = $urandom_range(1, 255);
        default: ry = $urandom;
      endcase
      apply($sformatf("rand%0d", i), ro, rx, ry, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
